sram_rw_req_adapter: RTL and testbench

//  Front-end stage that drives one single-port byte-masked SRAM wrapper: 6-bit addr, 32-bit data,
//  4-bit mask, RW0_* port style, synchronous read with 1-cycle latency.

---
 rtl/sram_rw_req_adapter.sv | 121 ++++++++++++
 tb/tb_sram_rw_req_adapter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_req_adapter.sv
// Request-channel front end for a single-port byte-masked SRAM (RW0_* style, 1-cycle read).
// Read data is caught into a small response FIFO; request credit keeps it from overflowing.
module sram_rw_req_adapter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = DATA_W / 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W:0]   DepthLim = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PtrMax   = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             inflight_q, inflight_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic             fire;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W:0]   credit_used;

    // Issue path: the SRAM sees the request directly, only sram_en is qualified.
    always_comb begin
        sram_en    = fire;
        sram_wmode = req_write;
        sram_addr  = req_addr;
        sram_wmask = req_wmask;
        sram_wdata = req_wdata;
    end

    // Credit counts both captured entries and the read whose data lands next cycle.
    // Taking pop into account lets a drained slot be reused in the same cycle.
    always_comb begin
        resp_valid  = (count_q != '0);
        pop         = resp_valid && resp_ready;
        push        = inflight_q;
        occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        credit_used = occupancy - {{CNT_W{1'b0}}, pop};
        req_ready   = reset_n && (credit_used < DepthLim);
        fire        = req_valid && req_ready;
        resp_rdata  = mem_q[rd_ptr_q];
    end

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = fire && !req_write;

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sram_rdata;
        end
    end

    credit_bound_a : assert property (
        @(posedge clock) disable iff (!reset_n) occupancy <= DepthLim
    );

    resp_hold_a : assert property (
        @(posedge clock) disable iff (!reset_n)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata))
    );

endmodule

// File: tb/tb_sram_rw_req_adapter.sv
// Randomized and directed bench for sram_rw_req_adapter with a behavioural SRAM and a
// transaction-level reference model (outstanding-read queue plus a shadow memory).
module tb_sram_rw_req_adapter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        sram_en;
    logic        sram_wmode;
    logic [5:0]  sram_addr;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    sram_rw_req_adapter #(
        .ADDR_W(6), .DATA_W(32), .MASK_W(4), .DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural SRAM: garbage on rdata whenever no read was strobed last cycle.
    logic [31:0] sram_mem [64];
    always @(posedge clock) begin
        if (sram_en && sram_wmode) begin
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= $urandom;
        end else if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Reference model: shadow memory plus queue of accepted reads with their issue cycle.
    typedef struct {
        logic [31:0] data;
        int          issue;
    } exp_t;

    logic [31:0] ref_mem [64];
    exp_t        q[$];
    logic [31:0] pop_log[$];
    int          cyc = 0;
    int          fires = 0;
    logic        last_acc = 1'b0;

    always @(negedge clock) begin
        logic exp_valid, pop, exp_ready, acc;
        cyc++;
        if (!reset_n) begin
            q.delete();
            last_acc = 1'b0;
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
        end else begin
            exp_valid = (q.size() > 0) && (q[0].issue + 2 <= cyc);
            pop       = exp_valid && resp_ready;
            exp_ready = (q.size() - (pop ? 1 : 0)) < DEPTH;
            acc       = req_valid && exp_ready;

            chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            chk("sram_en", {31'd0, sram_en}, {31'd0, acc});
            chk("sram_addr", {26'd0, sram_addr}, {26'd0, req_addr});
            chk("sram_wmask", {28'd0, sram_wmask}, {28'd0, req_wmask});
            chk("sram_wdata", sram_wdata, req_wdata);
            if (acc) chk("sram_wmode", {31'd0, sram_wmode}, {31'd0, req_write});
            if (exp_valid) chk("resp_rdata", resp_rdata, q[0].data);

            if (pop) begin
                pop_log.push_back(q[0].data);
                void'(q.pop_front());
            end
            if (acc) begin
                fires++;
                if (req_write) begin
                    for (int b = 0; b < 4; b++)
                        if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end else begin
                    q.push_back('{data: ref_mem[req_addr], issue: cyc});
                end
            end
            last_acc = acc;
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic req(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("req_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base_f, base_p, base_c;
        logic [5:0] a6;
        logic phase;

        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[9] = 32'h1122_3344;
        ref_mem[9]  = 32'h1122_3344;

        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);

        // 1: write then read back, 2-cycle latency
        base_f = fires;
        base_p = pop_log.size();
        resp_ready = 1'b1;
        req(1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
        req(1'b0, 6'd5, 32'h0, 4'h0);
        req_valid = 1'b0;
        @(negedge clock);
        chk("t1_lat_c1", {31'd0, resp_valid}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("t1_lat_c2", {31'd0, resp_valid}, 32'd1);
        @(posedge clock);
        #1;
        idle(2);
        chk("t1_fires", fires - base_f, 32'd2);
        chk("t1_npop", pop_log.size() - base_p, 32'd1);
        chk("t1_data", pop_log[base_p], 32'hDEAD_BEEF);

        // 2: partial-mask write
        base_p = pop_log.size();
        req(1'b1, 6'd9, 32'hAABB_CCDD, 4'b0101);
        req(1'b0, 6'd9, 32'h0, 4'h0);
        idle(4);
        chk("t2_data", pop_log[base_p], 32'h11BB_33DD);

        // 3: backpressure bounds outstanding reads to DEPTH
        resp_ready = 1'b0;
        base_f = fires;
        base_p = pop_log.size();
        req(1'b0, 6'd1, 32'h0, 4'h0);
        req(1'b0, 6'd2, 32'h0, 4'h0);
        req_addr = 6'd3;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        chk("t3_blocked", {31'd0, last_acc}, 32'd0);
        chk("t3_fires", fires - base_f, 32'd2);
        resp_ready = 1'b1;
        req(1'b0, 6'd3, 32'h0, 4'h0);
        idle(5);
        chk("t3_npop", pop_log.size() - base_p, 32'd3);
        chk("t3_d1", pop_log[base_p], 32'h1101_0101);
        chk("t3_d2", pop_log[base_p + 1], 32'h1202_0202);
        chk("t3_d3", pop_log[base_p + 2], 32'h1303_0303);

        // 4: streaming reads, one per cycle
        base_c = cyc;
        base_p = pop_log.size();
        for (int i = 0; i < 16; i++) req(1'b0, 6'(16 + i), 32'h0, 4'h0);
        chk("t4_cycles", cyc - base_c, 32'd16);
        idle(4);
        chk("t4_npop", pop_log.size() - base_p, 32'd16);
        chk("t4_first", pop_log[base_p], 32'h2010_1010);
        chk("t4_last", pop_log[base_p + 15], 32'h2F1F_1F1F);

        // 5: reset kills an in-flight read
        base_p = pop_log.size();
        req(1'b0, 6'd7, 32'h0, 4'h0);
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t5_no_resp", {31'd0, resp_valid}, 32'd0);
            @(posedge clock);
            #1;
        end
        req(1'b0, 6'd4, 32'h0, 4'h0);
        idle(4);
        chk("t5_npop", pop_log.size() - base_p, 32'd1);
        chk("t5_data", pop_log[base_p], 32'h1404_0404);

        // 6: random alternating write/read to one address with response stalls
        phase = 1'b0;
        a6 = 6'($urandom_range(0, 63));
        req_write = 1'b1;
        req_addr  = a6;
        req_wdata = $urandom;
        req_wmask = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clock);
            #1;
            if (last_acc) begin
                phase = ~phase;
                if (!phase) a6 = 6'($urandom_range(0, 63));
                req_write = !phase;
                req_addr  = a6;
                req_wdata = $urandom;
                req_wmask = 4'($urandom_range(0, 15));
            end
        end

        resp_ready = 1'b1;
        idle(8);
        chk("drain_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
